multicycle_main_ctrl: RTL and testbench

- Main control FSM for the multicycle RV32I datapath.
- Sits directly upstream of ALU_control: sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives ALUOp plus all datapath mux selects and write enables.
- Supported opcodes: lw, sw, R-type, I-type ALU, beq, jal.

---
 rtl/riscv_ctrl_pkg.sv | 38 +++
 rtl/imm_src_dec.sv | 13 +
 rtl/multicycle_main_ctrl.sv | 134 +++++++++++++
 tb/tb_multicycle_main_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: opcodes, FSM states and mux/ALUOp encodings shared by the RV32I controllers.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
    } state_t;

    // ALUOp values are also decoded by ALU_control
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/imm_src_dec.sv
// imm_src_dec: opcode to immediate-format select; unknown opcodes fall back to I-format.
module imm_src_dec
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] op_i,
    output logic [1:0] imm_src_o
);

    assign imm_src_o = (op_i == OP_SW)  ? IMM_S :
                       (op_i == OP_BEQ) ? IMM_B :
                       (op_i == OP_JAL) ? IMM_J : IMM_I;

endmodule

// File: rtl/multicycle_main_ctrl.sv
// multicycle_main_ctrl: Moore main control FSM for the multicycle RV32I datapath.
// Define MULTICYCLE_MAIN_CTRL_TRAP_EN to trap unsupported opcodes instead of skipping them.
module multicycle_main_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       RegWrite,
    output logic [1:0] ImmSrc,
    output logic       illegal_instr
);

`ifdef MULTICYCLE_MAIN_CTRL_TRAP_EN
    localparam logic [STATE_W-1:0] BAD_OP_NEXT = S_TRAP;
`else
    localparam logic [STATE_W-1:0] BAD_OP_NEXT = S_FETCH;
`endif

    logic [STATE_W-1:0] state_q, state_d;
    logic branch, pc_update, ir_write, mem_write, reg_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = S_DECODE;
            S_DECODE:   state_d = (op == OP_LW || op == OP_SW) ? S_MEMADR :
                                  (op == OP_R)   ? S_EXECUTER :
                                  (op == OP_I)   ? S_EXECUTEI :
                                  (op == OP_JAL) ? S_JAL :
                                  (op == OP_BEQ) ? S_BEQ : BAD_OP_NEXT;
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTER, S_EXECUTEI, S_JAL: state_d = S_ALUWB;
`ifdef MULTICYCLE_MAIN_CTRL_TRAP_EN
            S_TRAP:     state_d = S_TRAP;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        AdrSrc    = 1'b0;
        ir_write  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        branch    = 1'b0;
        pc_update = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        ALUOp     = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                ir_write  = 1'b1;
                pc_update = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = SRCA_RS1;
                ALUOp   = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_FUNCT;
            end
            S_ALUWB:    reg_write = 1'b1;
            S_BEQ: begin
                ALUSrcA = SRCA_RS1;
                ALUOp   = ALUOP_SUB;
                branch  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    // write enables are gated so nothing commits while reset is held
    assign PCWrite  = rst_n & ((branch & zero) | pc_update);
    assign IRWrite  = rst_n & ir_write;
    assign MemWrite = rst_n & mem_write;
    assign RegWrite = rst_n & reg_write;

`ifdef MULTICYCLE_MAIN_CTRL_TRAP_EN
    assign illegal_instr = (state_q == S_TRAP);
`else
    assign illegal_instr = 1'b0;
`endif

    imm_src_dec u_imm_src_dec (
        .op_i      (op),
        .imm_src_o (ImmSrc)
    );

endmodule

// File: tb/tb_multicycle_main_ctrl.sv
// tb_multicycle_main_ctrl: directed per-instruction control sequences against hand-derived vectors.
module tb_multicycle_main_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic       zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_instr;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic [13:0] obs;
    int n_checks = 0;
    int n_fail = 0;

    // {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,RegWrite,illegal_instr}
    localparam logic [13:0] F_V   = 14'b1_0_0_1_10_00_10_00_0_0;
    localparam logic [13:0] D_V   = 14'b0_0_0_0_00_01_01_00_0_0;
    localparam logic [13:0] MA_V  = 14'b0_0_0_0_00_10_01_00_0_0;
    localparam logic [13:0] MR_V  = 14'b0_1_0_0_00_00_00_00_0_0;
    localparam logic [13:0] MWB_V = 14'b0_0_0_0_01_00_00_00_1_0;
    localparam logic [13:0] MW_V  = 14'b0_1_1_0_00_00_00_00_0_0;
    localparam logic [13:0] XR_V  = 14'b0_0_0_0_00_10_00_10_0_0;
    localparam logic [13:0] XI_V  = 14'b0_0_0_0_00_10_01_10_0_0;
    localparam logic [13:0] AWB_V = 14'b0_0_0_0_00_00_00_00_1_0;
    localparam logic [13:0] BQ1_V = 14'b1_0_0_0_00_10_00_01_0_0;
    localparam logic [13:0] BQ0_V = 14'b0_0_0_0_00_10_00_01_0_0;
    localparam logic [13:0] JL_V  = 14'b1_0_0_0_00_01_10_00_0_0;
    localparam logic [13:0] RST_V = 14'b0_0_0_0_10_00_10_00_0_0;
    localparam logic [13:0] TRP_V = 14'b0_0_0_0_00_00_00_00_0_1;

    multicycle_main_ctrl #(.STATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .RegWrite(RegWrite), .ImmSrc(ImmSrc), .illegal_instr(illegal_instr)
    );

    assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, RegWrite, illegal_instr};

    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (obs !== RST_V) begin n_fail++; $display("FAIL reset_held: got %b want %b", obs, RST_V); end
        #2 rst_n = 1'b1;
        #1;
        n_checks++;
        if (obs !== F_V) begin n_fail++; $display("FAIL reset_release: got %b want %b", obs, F_V); end
    endtask

    task automatic test_lw();
        logic [13:0] s[$] = '{F_V, D_V, MA_V, MR_V, MWB_V};
        op = 7'b0000011;
        zero = 1'b0;
        foreach (s[i]) begin
            n_checks++;
            if (obs !== s[i]) begin n_fail++; $display("FAIL lw_cyc%0d: got %b want %b", i, obs, s[i]); end
            if (i == 1) begin
                n_checks++;
                if (ImmSrc !== 2'b00) begin n_fail++; $display("FAIL lw_immsrc: got %b want 00", ImmSrc); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_rtype();
        logic [13:0] s[$] = '{F_V, D_V, XR_V, AWB_V};
        op = 7'b0110011;
        foreach (s[i]) begin
            n_checks++;
            if (obs !== s[i]) begin n_fail++; $display("FAIL rtype_cyc%0d: got %b want %b", i, obs, s[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_itype();
        logic [13:0] s[$] = '{F_V, D_V, XI_V, AWB_V};
        op = 7'b0010011;
        foreach (s[i]) begin
            n_checks++;
            if (obs !== s[i]) begin n_fail++; $display("FAIL itype_cyc%0d: got %b want %b", i, obs, s[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_beq(input logic z);
        logic [13:0] s[$] = '{F_V, D_V, z ? BQ1_V : BQ0_V};
        op = 7'b1100011;
        zero = z;
        foreach (s[i]) begin
            n_checks++;
            if (obs !== s[i]) begin n_fail++; $display("FAIL beq_z%0b_cyc%0d: got %b want %b", z, i, obs, s[i]); end
            if (i == 2) begin
                n_checks++;
                if (ImmSrc !== 2'b10) begin n_fail++; $display("FAIL beq_immsrc: got %b want 10", ImmSrc); end
            end
            @(negedge clk);
        end
        zero = 1'b0;
    endtask

    task automatic test_sw();
        logic [13:0] s[$] = '{F_V, D_V, MA_V, MW_V};
        op = 7'b0100011;
        foreach (s[i]) begin
            n_checks++;
            if (obs !== s[i]) begin n_fail++; $display("FAIL sw_cyc%0d: got %b want %b", i, obs, s[i]); end
            if (i == 3) begin
                n_checks++;
                if (ImmSrc !== 2'b01) begin n_fail++; $display("FAIL sw_immsrc: got %b want 01", ImmSrc); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_jal();
        logic [13:0] s[$] = '{F_V, D_V, JL_V, AWB_V};
        op = 7'b1101111;
        zero = 1'b1;
        foreach (s[i]) begin
            n_checks++;
            if (obs !== s[i]) begin n_fail++; $display("FAIL jal_cyc%0d: got %b want %b", i, obs, s[i]); end
            if (i == 2) begin
                n_checks++;
                if (ImmSrc !== 2'b11) begin n_fail++; $display("FAIL jal_immsrc: got %b want 11", ImmSrc); end
            end
            @(negedge clk);
        end
        zero = 1'b0;
    endtask

    task automatic test_reset_mid_memwrite();
        logic [13:0] s[$] = '{F_V, D_V, MA_V, MW_V};
        logic [13:0] r[$] = '{D_V, MA_V, MW_V};
        op = 7'b0100011;
        foreach (s[i]) begin
            n_checks++;
            if (obs !== s[i]) begin n_fail++; $display("FAIL rstmw_pre_cyc%0d: got %b want %b", i, obs, s[i]); end
            if (i < 3) @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== RST_V) begin n_fail++; $display("FAIL rstmw_assert: got %b want %b", obs, RST_V); end
        @(negedge clk);
        n_checks++;
        if (obs !== RST_V) begin n_fail++; $display("FAIL rstmw_held: got %b want %b", obs, RST_V); end
        #2 rst_n = 1'b1;
        #1;
        n_checks++;
        if (obs !== F_V) begin n_fail++; $display("FAIL rstmw_release: got %b want %b", obs, F_V); end
        foreach (r[i]) begin
            @(negedge clk);
            n_checks++;
            if (obs !== r[i]) begin n_fail++; $display("FAIL rstmw_post_cyc%0d: got %b want %b", i, obs, r[i]); end
        end
        @(negedge clk);
    endtask

    task automatic test_unsupported();
        logic [13:0] s[$] = '{F_V, D_V};
        op = 7'b1111111;
        foreach (s[i]) begin
            n_checks++;
            if (obs !== s[i]) begin n_fail++; $display("FAIL badop_cyc%0d: got %b want %b", i, obs, s[i]); end
            @(negedge clk);
        end
        n_checks++;
        if (ImmSrc !== 2'b00) begin n_fail++; $display("FAIL badop_immsrc: got %b want 00", ImmSrc); end
`ifdef MULTICYCLE_MAIN_CTRL_TRAP_EN
        for (int k = 0; k < 10; k++) begin
            n_checks++;
            if (obs !== TRP_V) begin n_fail++; $display("FAIL trap_cyc%0d: got %b want %b", k, obs, TRP_V); end
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== RST_V) begin n_fail++; $display("FAIL trap_reset: got %b want %b", obs, RST_V); end
        #2 rst_n = 1'b1;
        #1;
`endif
        n_checks++;
        if (obs !== F_V) begin n_fail++; $display("FAIL badop_back_to_fetch: got %b want %b", obs, F_V); end
    endtask

    initial begin
        rst_n = 1'b0;
        op = 7'b0;
        zero = 1'b0;
        test_reset();
        test_lw();
        test_rtype();
        test_itype();
        test_beq(1'b1);
        test_beq(1'b0);
        test_sw();
        test_jal();
        test_reset_mid_memwrite();
        test_unsupported();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
